// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter that drives the select input of a one-hot word mux.
// It grants one requester at a time and holds that grant for a whole burst.
// A burst ends when the owner's beat flagged last is accepted, or when the
// owner drops its request. At that point the arbiter hands over to the next
// requester in rotating order, with no idle cycle in between.
//
// Handshake: in BUSY, valid_o is 1 and a beat transfers on any rising edge
// where ready_i is also 1. last_i qualifies that transferred beat as the end
// of the owner's burst. req_i, last_i and ready_i are sampled on the rising
// edge. All outputs are registered and depend only on arbiter state.
module onehot_rr_arbiter #(
  parameter int Count    = 3,
  parameter int IdxWidth = $clog2(Count)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [Count-1:0]    req_i,
  input  logic                last_i,
  input  logic                ready_i,
  output logic [Count-1:0]    grant_o,
  output logic                valid_o,
  output logic [IdxWidth-1:0] grant_idx_o,
  output logic                dbg_state_o
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(Count - 1);

  state_t              state;
  logic [IdxWidth-1:0] ptr;

  logic                owner_req;
  logic                burst_end;
  logic [IdxWidth-1:0] nxt_ptr;
  logic [Count-1:0]    rq;
  logic [IdxWidth-1:0] idle_pick;
  logic [IdxWidth-1:0] busy_pick;

  // Expand an index into a one-hot vector.
  function automatic logic [Count-1:0] onehot(input logic [IdxWidth-1:0] idx);
    logic [Count-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Return the first set bit of rqv, scanning from base upward and wrapping
  // modulo Count, so the index never exceeds Count-1.
  function automatic logic [IdxWidth-1:0] pick(input logic [IdxWidth-1:0] base,
                                               input logic [Count-1:0]    rqv);
    logic [IdxWidth-1:0] res;
    logic                found;
    int                  idx;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < Count; i++) begin
      idx = (int'(base) + i) % Count;
      if (!found && rqv[idx]) begin
        res   = IdxWidth'(idx);
        found = 1'b1;
      end
    end
    return res;
  endfunction

  assign dbg_state_o = logic'(state);

  // Burst-end detection and the two candidate winners: one for a fresh
  // arbitration from IDLE, and one for a hand-over at the end of a burst.
  // grant_idx_o holds the current owner while BUSY. During a hand-over, the
  // old owner is masked so that it competes again only from the next cycle.
  always_comb begin
    owner_req = req_i[grant_idx_o];
    burst_end = (ready_i & last_i) | !owner_req;
    nxt_ptr   = (grant_idx_o == LastIdx) ? '0 : grant_idx_o + 1'b1;
    rq        = req_i & ~onehot(grant_idx_o);
    idle_pick = pick(ptr, req_i);
    busy_pick = pick(nxt_ptr, rq);
  end

  // Arbiter FSM. State, the priority pointer and the registered grant
  // outputs all update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      grant_o     <= '0;
      valid_o     <= 1'b0;
      grant_idx_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_i) begin
            state       <= BUSY;
            grant_o     <= onehot(idle_pick);
            valid_o     <= 1'b1;
            grant_idx_o <= idle_pick;
          end
        end
        BUSY: begin
          if (burst_end) begin
            ptr <= nxt_ptr;
            if (|rq) begin
              grant_o     <= onehot(busy_pick);
              valid_o     <= 1'b1;
              grant_idx_o <= busy_pick;
            end else begin
              state       <= IDLE;
              grant_o     <= '0;
              valid_o     <= 1'b0;
              grant_idx_o <= '0;
            end
          end
        end
        default: begin
          state       <= IDLE;
          grant_o     <= '0;
          valid_o     <= 1'b0;
          grant_idx_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed bench for onehot_rr_arbiter with Count=3. It finishes with a
// randomised fairness run for requester 2.
module tb_onehot_rr_arbiter;

  localparam int Count    = 3;
  localparam int IdxWidth = $clog2(Count);

  // clock / reset
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [Count-1:0]    req = '0;
  logic                last = 1'b0;
  logic                ready = 1'b0;
  logic [Count-1:0]    grant;
  logic                valid;
  logic [IdxWidth-1:0] grant_idx;
  logic                dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  onehot_rr_arbiter #(.Count(Count), .IdxWidth(IdxWidth)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .last_i      (last),
    .ready_i     (ready),
    .grant_o     (grant),
    .valid_o     (valid),
    .grant_idx_o (grant_idx),
    .dbg_state_o (dbg_state)
  );

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [Count-1:0] r, input logic rd, input logic ls);
    req   = r;
    ready = rd;
    last  = ls;
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [Count-1:0] eg,
                     input logic ev, input logic [IdxWidth-1:0] ei);
    total_cnt++;
    assert (grant === eg && valid === ev && grant_idx === ei) pass_cnt++;
    else $error("FAIL %s: got grant=%b valid=%b idx=%0d, expected grant=%b valid=%b idx=%0d",
                tag, grant, valid, grant_idx, eg, ev, ei);
  endtask

  task automatic chk_inv(input string tag);
    logic ok;
    ok = (grant == 3'b000 || grant == 3'b001 || grant == 3'b010 || grant == 3'b100)
         && (valid == |grant)
         && (valid ? (int'(grant_idx) < Count && grant[grant_idx] == 1'b1)
                   : (grant_idx == '0));
    total_cnt++;
    assert (ok === 1'b1) pass_cnt++;
    else $error("FAIL %s: invariant broken grant=%b valid=%b idx=%0d, expected consistent one-hot",
                tag, grant, valid, grant_idx);
  endtask

  initial begin
    int ends;
    logic seen;

    // reset state while reset is held
    #3;
    chk("reset_hold", 3'b000, 1'b0, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    // idle: no requests for 5 cycles
    drive(3'b000, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle", 3'b000, 1'b0, 2'd0);
    end

    // full rotation with single-beat bursts
    drive(3'b111, 1'b1, 1'b1);
    step(); chk("rot0", 3'b001, 1'b1, 2'd0);
    step(); chk("rot1", 3'b010, 1'b1, 2'd1);
    step(); chk("rot2", 3'b100, 1'b1, 2'd2);
    step(); chk("rot3", 3'b001, 1'b1, 2'd0);

    // owner 0: 3-beat burst, ready pattern 1,0,1,1, last on the 3rd accepted beat
    drive(3'b011, 1'b1, 1'b0); step(); chk("burst_a", 3'b001, 1'b1, 2'd0);
    drive(3'b011, 1'b0, 1'b0); step(); chk("burst_b", 3'b001, 1'b1, 2'd0);
    drive(3'b011, 1'b1, 1'b0); step(); chk("burst_c", 3'b001, 1'b1, 2'd0);
    drive(3'b011, 1'b1, 1'b1); step(); chk("burst_handover", 3'b010, 1'b1, 2'd1);

    // owner 1 aborts by dropping its request with no transfer
    drive(3'b100, 1'b0, 1'b0); step(); chk("abort", 3'b100, 1'b1, 2'd2);
    // owner 2 takes its last beat and nobody else requests -> idle
    drive(3'b100, 1'b1, 1'b1); step(); chk("to_idle", 3'b000, 1'b0, 2'd0);

    // idle stretch leaves ptr at 0, so requester 1 wins over requester 2
    drive(3'b000, 1'b0, 1'b0);
    step(); step(); step();
    chk("idle_again", 3'b000, 1'b0, 2'd0);
    drive(3'b110, 1'b0, 1'b0); step(); chk("ptr_kept", 3'b010, 1'b1, 2'd1);

    // new requests do not pre-empt the owner
    drive(3'b111, 1'b0, 1'b0); step(); chk("no_preempt0", 3'b010, 1'b1, 2'd1);
    drive(3'b111, 1'b1, 1'b0); step(); chk("no_preempt1", 3'b010, 1'b1, 2'd1);

    // last transfer and request drop in the same cycle behave as one end
    drive(3'b101, 1'b1, 1'b1); step(); chk("last_and_drop", 3'b100, 1'b1, 2'd2);

    // asynchronous reset mid-burst
    drive(3'b101, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 chk("async_rst", 3'b000, 1'b0, 2'd0);
    #2 rst = 1'b0;
    step(); chk("after_rst", 3'b001, 1'b1, 2'd0);

    // the old owner is masked only during the hand-over cycle
    drive(3'b001, 1'b1, 1'b1); step(); chk("mask_once", 3'b000, 1'b0, 2'd0);
    drive(3'b001, 1'b0, 1'b0); step(); chk("regrant", 3'b001, 1'b1, 2'd0);

    // fairness: requester 2 held high, the others random
    for (int round = 0; round < 6; round++) begin
      ends = 0;
      seen = 1'b0;
      for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
        if (grant == 3'b100) begin
          seen = 1'b1;
        end else begin
          drive({1'b1, 2'($urandom_range(0, 3))}, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)));
          if (valid && ((ready && last) || !req[grant_idx])) ends++;
          step();
          chk_inv("inv_rand");
        end
      end
      total_cnt++;
      assert (seen === 1'b1 && ends <= Count - 1) pass_cnt++;
      else $error("FAIL starve: got seen=%0b ends=%0d, expected seen=1 ends<=%0d",
                  seen, ends, Count - 1);
      // finish requester 2's burst and let the others continue
      drive({1'b1, 2'($urandom_range(0, 3))}, 1'b1, 1'b1);
      step();
      chk_inv("inv_release");
      drive({1'b0, 2'($urandom_range(1, 3))}, 1'b1, 1'b1);
      step();
      chk_inv("inv_release2");
    end

    // final report
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
